// File: rtl/calc_div_cmp_disp_pkg.sv
// rtl/calc_div_cmp_disp_pkg.sv - shared types and constants for the divider/comparator/display block
package calc_div_cmp_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  localparam logic [7:0] CMP_GT = 8'h01;
  localparam logic [7:0] CMP_EQ = 8'h02;
  localparam logic [7:0] CMP_LT = 8'h04;

  // Active-low segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/calc_div_cmp_disp_seg.sv
// rtl/calc_div_cmp_disp_seg.sv - combinational BCD to seven-segment decoder
module bcd_seg_decoder
  import calc_div_cmp_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_low;

  // Look up the active-low pattern; codes above 9 blank the display
  always_comb begin
    seg_low = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_low = SEG_0;
      4'd1:    seg_low = SEG_1;
      4'd2:    seg_low = SEG_2;
      4'd3:    seg_low = SEG_3;
      4'd4:    seg_low = SEG_4;
      4'd5:    seg_low = SEG_5;
      4'd6:    seg_low = SEG_6;
      4'd7:    seg_low = SEG_7;
      4'd8:    seg_low = SEG_8;
      4'd9:    seg_low = SEG_9;
      default: seg_low = SEG_BLANK;
    endcase
  end

  assign seg_o = SEG_ACTIVE_LOW ? seg_low : ~seg_low;

endmodule

// File: rtl/calc_div_cmp_disp.sv
// rtl/calc_div_cmp_disp.sv - sequential restoring divider, registered comparator and 7-seg display
module calc_div_cmp_disp
  import calc_div_cmp_disp_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] valueA,
  input  logic [WIDTH-1:0] valueB,
  input  logic [3:0]       bcd,
  output logic [7:0]       Quotient,
  output logic [7:0]       Reminder,
  output logic [7:0]       comparator,
  output logic             busy,
  output logic [6:0]       segment
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] dvd_q, rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_q;
  logic [7:0]       quot_q, remo_q, cmp_q;

  logic [WIDTH:0]   shifted;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             start;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The difference always fits WIDTH bits when kept, so the low bits suffice.
  always_comb begin
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, b_q});
    rem_d     = no_borrow ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], no_borrow};
    start     = pend_q || ({valueA, valueB} != {a_q, b_q});
  end

  // Divider FSM: latch a new operand pair in IDLE, iterate WIDTH steps in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b1;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= valueA;
            b_q     <= valueB;
            dvd_q   <= valueA;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_q  <= 8'(quo_d);
            remo_q  <= 8'(rem_d);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Comparator follows the live operands with one cycle of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= '0;
    end else if (valueA > valueB) begin
      cmp_q <= CMP_GT;
    end else if (valueA == valueB) begin
      cmp_q <= CMP_EQ;
    end else begin
      cmp_q <= CMP_LT;
    end
  end

  assign Quotient   = quot_q;
  assign Reminder   = remo_q;
  assign comparator = cmp_q;
  assign busy       = (state_q == RUN);

  bcd_seg_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg (
    .bcd_i(bcd),
    .seg_o(segment)
  );

endmodule

// File: tb/tb_calc_div_cmp_disp.sv
// tb/tb_calc_div_cmp_disp.sv - scoreboard testbench for calc_div_cmp_disp
module tb_calc_div_cmp_disp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valueA = 4'd13;
  logic [3:0] valueB = 4'd4;
  logic [3:0] bcd = 4'd0;
  logic [7:0] Quotient, Reminder, comparator;
  logic       busy;
  logic [6:0] segment;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic        busy_prev = 1'b0;
  int          busy_cnt = 0;

  calc_div_cmp_disp #(.WIDTH(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .valueA(valueA), .valueB(valueB), .bcd(bcd),
    .Quotient(Quotient), .Reminder(Reminder), .comparator(comparator),
    .busy(busy), .segment(segment)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_div(input logic [7:0] q, input logic [7:0] r);
    exp_q.push_back({q, r});
  endtask

  // Wait until the divider has been idle for three consecutive samples
  task automatic wait_quiet();
    int quiet = 0;
    for (int i = 0; i < 60 && quiet < 3; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    chk("quiet_timeout", 32'(quiet >= 3), 32'd1);
  endtask

  // Monitor: every completed run (busy falling outside reset) pops one expectation
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {16'h0, Quotient, Reminder}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("quotient", 32'(Quotient), 32'(e[15:8]));
          chk("remainder", 32'(Reminder), 32'(e[7:0]));
          chk("busy_cycles", 32'(busy_cnt), 32'd4);
        end
        busy_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_quotient", 32'(Quotient), 32'h0);
    chk("rst_remainder", 32'(Reminder), 32'h0);
    chk("rst_comparator", 32'(comparator), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Release with 13/4: latch edge, four RUN edges, result on the 5th edge
    push_div(8'd3, 8'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat_busy_still", 32'(busy), 32'd1);
    chk("lat_q_not_yet", 32'(Quotient), 32'h0);
    @(negedge clk);
    chk("lat_q_5th_edge", 32'(Quotient), 32'd3);
    chk("lat_busy_done", 32'(busy), 32'd0);
    wait_quiet();

    // Divide by zero
    valueA = 4'd7; valueB = 4'd0;
    push_div(8'h0F, 8'h07);
    wait_quiet();

    // Comparator sequence; 9/9 lands mid-run and is superseded by 12/3
    valueA = 4'd5; valueB = 4'd9;
    push_div(8'd0, 8'd5);
    @(negedge clk);
    chk("cmp_lt", 32'(comparator), 32'h04);
    valueA = 4'd9; valueB = 4'd9;
    @(negedge clk);
    chk("cmp_eq", 32'(comparator), 32'h02);
    valueA = 4'd12; valueB = 4'd3;
    @(negedge clk);
    chk("cmp_gt", 32'(comparator), 32'h01);
    push_div(8'd4, 8'd0);
    wait_quiet();

    // Operand change during RUN triggers a second division
    valueA = 4'd13; valueB = 4'd4;
    push_div(8'd3, 8'd1);
    @(negedge clk);
    chk("run_started", 32'(busy), 32'd1);
    valueA = 4'd15;
    push_div(8'd3, 8'd3);
    wait_quiet();

    // Reset mid-run clears outputs without a clock edge
    valueA = 4'd11; valueB = 4'd2;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_quotient", 32'(Quotient), 32'h0);
    chk("abort_remainder", 32'(Reminder), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_comparator", 32'(comparator), 32'h0);
    repeat (2) @(negedge clk);
    push_div(8'd5, 8'd1);
    rst = 1'b0;
    wait_quiet();

    // Segment sweep
    for (int i = 0; i < 16; i++) begin
      bcd = 4'(i);
      #1;
      chk($sformatf("seg_%0d", i), 32'(segment), 32'(seg_tab[i]));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_div_cmp_disp.md
CALC_DIV_CMP_DISP -- requirements
Module: calc_div_cmp_disp

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; results are zero-extended to 8 bits.
REQ-002 Parameter: SEG_ACTIVE_LOW, default 1; 1 means a lit segment is driven 0.
REQ-003 Clocking: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-004 Port: clk, input, 1, rising-edge system clock.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: valueA, input, 4, dividend and comparator operand A.
REQ-007 Port: valueB, input, 4, divisor and comparator operand B.
REQ-008 Port: bcd, input, 4, digit to display.
REQ-009 Port: Quotient, output, 8, registered quotient, zero-extended.
REQ-010 Port: Reminder, output, 8, registered remainder, zero-extended.
REQ-011 Port: comparator, output, 8, registered compare code.
REQ-012 Port: busy, output, 1, high while a division is running.
REQ-013 Port: segment, output, 7, seven-segment pattern; bit0=a through bit6=g.

Function
REQ-014 Divider FSM states: IDLE and RUN.
REQ-015 In IDLE, a division SHALL start at a clock edge when {valueA,valueB} differs from the last latched pair, or when the start-pending flag is set.
  - At that edge, latch both operands, clear the partial remainder, set the step count to 0, go to RUN.
  - Clear the start-pending flag.
REQ-016 RUN SHALL perform one restoring-division step per clock, MSB first, for exactly WIDTH (4) steps.
  - Each step: shift {rem, dividend-bit}.
  - Trial-subtract the divisor using a 5-bit compare.
  - Quotient bit = 1 if no borrow, else restore.
REQ-017 On the 4th RUN edge, Quotient and Reminder SHALL update and the FSM SHALL return to IDLE.
  - Latency: results appear 4 edges after the latch edge.
  - Quotient and Reminder hold their values at all other times.
REQ-018 busy SHALL be 1 exactly during RUN.
REQ-019 Operand changes during RUN SHALL be ignored for the current division.
  - They are compared against the latched pair once the FSM returns to IDLE.
  - A change therefore triggers a fresh division on the first IDLE edge.
REQ-020 Divisor 0 needs no special path: the algorithm SHALL yield Quotient=8'h0F and Reminder=dividend.
REQ-021 comparator SHALL register every clock from the current valueA and valueB (1-cycle latency):
  - 8'h01 if A>B
  - 8'h02 if A==B
  - 8'h04 if A<B
REQ-022 segment SHALL be purely combinational from bcd.
  - Digits 0-9 use standard patterns; active-low, e.g. 0 -> 7'b1000000 and 8 -> 7'b0000000.
  - Codes 10-15 SHALL blank the display (7'b1111111 when active-low).
  - When SEG_ACTIVE_LOW=0, the output SHALL be the bitwise inverse.

Reset
REQ-023 On rst=1 (asynchronous), the FSM SHALL enter IDLE and outputs SHALL clear.
  - Quotient=0, Reminder=0, comparator=0, busy=0.
  - Latched operands=0 and step count=0.
  - Start-pending flag=1.
REQ-024 After rst deasserts, the first rising edge SHALL start a division of the current operands.
REQ-025 rst asserted during RUN SHALL abort the division without updating results.
  - Quotient and Reminder go to 0.
  - A new division follows release as per REQ-024.
REQ-026 segment has no reset dependency.

Structure
REQ-027 A shared package SHALL hold:
  - the divider state typedef (IDLE, RUN)
  - the comparator codes CMP_GT, CMP_EQ, CMP_LT
  - the ten digit segment constants and SEG_BLANK
REQ-028 The seven-segment decode SHALL be one sub-module, bcd_seg_decoder; the divider and comparator stay in the top.

Verification
REQ-029 Scenario: reset release with A=13, B=4.
  - busy is high for 4 cycles.
  - Quotient=3 and Reminder=1 on the 5th edge after release, i.e. 4 edges after the latch edge.
REQ-030 Scenario: A=7, B=0 -> Quotient=8'h0F, Reminder=8'h07 after a full run.
REQ-031 Scenario: A=5, B=9 -> comparator=8'h04 one edge later; then A=9, B=9 -> 8'h02; then A=12, B=3 -> 8'h01.
REQ-032 Scenario: change A from 13 to 15 (B=4) during RUN.
  - The first result is 3 r1.
  - A second run follows and gives 3 r3.
REQ-033 Scenario: sweep bcd 0-15 -> bcd 0 gives 7'b1000000, bcd 8 gives 7'b0000000, bcd 10-15 give 7'b1111111.
REQ-034 Scenario: assert rst mid-RUN.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the current operands are recomputed.
